// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared types and helpers for the FIFO write-port arbiter.
//   arb_state_e   : arbiter FSM states (IDLE, LOCKED)
//   CNT_WIDTH_DEF : default statistics counter width
//   rr_next()     : round-robin pointer increment with wrap at n
package fifo_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  localparam int CNT_WIDTH_DEF = 16;

  function automatic int rr_next(input int ptr, input int n);
    return (ptr >= n - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/fifo_rr_picker.sv
// fifo_rr_picker: combinational round-robin selector.
//   req     in  NUM_REQ  request vector
//   rr_ptr  in  IDW      last winner; search starts at rr_ptr+1
//   win_id  out IDW      first requester found with req set
//   any_vld out 1        at least one req bit is set
module fifo_rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     rr_ptr,
  output logic [IDW-1:0]     win_id,
  output logic               any_vld
);

  always_comb begin
    logic [IDW-1:0] idx;
    win_id  = '0;
    any_vld = 1'b0;
    idx     = IDW'(rr_next(int'(rr_ptr), NUM_REQ));
    // First hit in the rotated order wins; later hits are masked by any_vld.
    for (int k = 0; k < NUM_REQ; k++) begin
      if (req[idx] && !any_vld) begin
        any_vld = 1'b1;
        win_id  = idx;
      end
      idx = IDW'(rr_next(int'(idx), NUM_REQ));
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin, packet-locked arbiter for an async FIFO
// write port (wr_clk domain). A granted producer owns the port until its
// last beat is accepted; writes are suppressed whenever fifo_full is high.
//   wr_clk, wr_rst         clock, synchronous active-high reset
//   req_valid/data/last    per-requester beat stream (data slice i = req i)
//   req_ready              per-requester accept
//   fifo_full              FIFO full flag
//   fifo_wr_en/wr_data     FIFO write port (combinational from state)
//   grant_id, busy         current owner / packet in progress
// Optional build macro FIFO_WR_ARB_STATS_EN adds stats_clr, beat_cnt,
// stall_cnt and the CNT_WIDTH parameter (saturating counters).
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int IDW        = $clog2(NUM_REQ)
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF
`endif
) (
  input  logic                          wr_clk,
  input  logic                          wr_rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  output logic [IDW-1:0]                grant_id,
  output logic                          busy
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  input  logic                          stats_clr,
  output logic [NUM_REQ*CNT_WIDTH-1:0]  beat_cnt,
  output logic [CNT_WIDTH-1:0]          stall_cnt
`endif
);

  arb_state_e     state, state_nxt;
  logic [IDW-1:0] rr_ptr, win_id;
  logic           any_vld, own_vld, own_last, accept;

  fifo_rr_picker #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_picker (
    .req     (req_valid),
    .rr_ptr  (rr_ptr),
    .win_id  (win_id),
    .any_vld (any_vld)
  );

  assign busy       = (state == LOCKED);
  assign own_vld    = req_valid[grant_id];
  assign own_last   = req_last[grant_id];
  assign accept     = busy & own_vld & ~fifo_full;
  assign fifo_wr_en = accept;

  always_comb begin
    req_ready    = '0;
    fifo_wr_data = '0;
    if (busy) begin
      req_ready[grant_id] = ~fifo_full;
      fifo_wr_data        = req_data[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_vld) state_nxt = LOCKED;
      LOCKED:  if (accept && own_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wr_clk) begin
    if (wr_rst) begin
      state    <= IDLE;
      grant_id <= '0;
      rr_ptr   <= IDW'(NUM_REQ - 1);
    end else begin
      state <= state_nxt;
      if (state == IDLE && any_vld) grant_id <= win_id;
      if (accept && own_last)       rr_ptr   <= grant_id;
    end
  end

`ifdef FIFO_WR_ARB_STATS_EN
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_beat
    logic [CNT_WIDTH-1:0] cnt;
    always_ff @(posedge wr_clk) begin
      if (wr_rst || stats_clr)
        cnt <= '0;
      else if (accept && grant_id == IDW'(i) && cnt != CNT_MAX)
        cnt <= cnt + 1'b1;
    end
    assign beat_cnt[i*CNT_WIDTH +: CNT_WIDTH] = cnt;
  end

  // Counts only cycles where the owner actually has a beat blocked by full.
  always_ff @(posedge wr_clk) begin
    if (wr_rst || stats_clr)
      stall_cnt <= '0;
    else if (busy && own_vld && fifo_full && stall_cnt != CNT_MAX)
      stall_cnt <= stall_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter (NUM_REQ=4, DATA_WIDTH=8).
// Build with FIFO_WR_ARB_STATS_EN defined to also cover the counters
// (CNT_WIDTH=4 there so saturation is reachable).
module tb_fifo_wr_arbiter;
  localparam int NR  = 4;
  localparam int DW  = 8;
  localparam int IDW = 2;
`ifdef FIFO_WR_ARB_STATS_EN
  localparam int CW  = 4;
`endif

  logic              clk = 1'b0;
  logic              wr_rst;
  logic [NR-1:0]     req_valid, req_last, req_ready;
  logic [NR*DW-1:0]  req_data;
  logic              fifo_full, fifo_wr_en;
  logic [DW-1:0]     fifo_wr_data;
  logic [IDW-1:0]    grant_id;
  logic              busy;
`ifdef FIFO_WR_ARB_STATS_EN
  logic              stats_clr;
  logic [NR*CW-1:0]  beat_cnt;
  logic [CW-1:0]     stall_cnt;
`endif

  fifo_wr_arbiter #(
    .NUM_REQ(NR), .DATA_WIDTH(DW), .IDW(IDW)
`ifdef FIFO_WR_ARB_STATS_EN
    , .CNT_WIDTH(CW)
`endif
  ) dut (
    .wr_clk(clk), .wr_rst(wr_rst),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .fifo_full(fifo_full),
    .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
    .grant_id(grant_id), .busy(busy)
`ifdef FIFO_WR_ARB_STATS_EN
    , .stats_clr(stats_clr), .beat_cnt(beat_cnt), .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Producer beat stores (ring of 32 per requester) and FIFO scoreboard {grant, data}.
  logic [7:0]    pd [NR][32];
  logic          pl [NR][32];
  int            wp [NR];
  int            rp [NR];
  logic [NR-1:0] hold;
  logic [NR-1:0] acc_s;
  logic [9:0]    exp_q [$];

  // Acceptance is sampled mid-cycle, when inputs and state are stable.
  always @(negedge clk) acc_s = req_valid & req_ready;

  // Producers: advance on accept, present the head beat just after the edge.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NR; i++) begin
      if (acc_s[i] === 1'b1) rp[i] = rp[i] + 1;
      if (rp[i] != wp[i] && !hold[i]) begin
        req_valid[i]           = 1'b1;
        req_data[i*DW +: DW]   = pd[i][rp[i] % 32];
        req_last[i]            = pl[i][rp[i] % 32];
      end else begin
        req_valid[i] = 1'b0;
        req_last[i]  = 1'b0;
      end
    end
  end

  // FIFO side: every write must match the next predicted {grant, data}.
  always @(negedge clk) begin
    if (fifo_wr_en === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected_write got grant=%0d data=%h exp none", grant_id, fifo_wr_data);
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        if ({grant_id, fifo_wr_data} !== e) begin
          n_err++;
          $display("FAIL sb_write got grant=%0d data=%h exp grant=%0d data=%h",
                   grant_id, fifo_wr_data, e[9:8], e[7:0]);
        end
      end
    end
  end

  task automatic load(input int i, input logic [7:0] d, input logic l);
    pd[i][wp[i] % 32] = d;
    pl[i][wp[i] % 32] = l;
    wp[i] = wp[i] + 1;
  endtask

  task automatic exp_push(input int g, input logic [7:0] d);
    exp_q.push_back({2'(g), d});
  endtask

  task automatic do_reset();
    @(negedge clk);
    for (int i = 0; i < NR; i++) rp[i] = wp[i];
    hold = '0;
    @(posedge clk); #1;
    wr_rst = 1'b1; fifo_full = 1'b0;
    @(posedge clk); #1;
    wr_rst = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({busy, fifo_wr_en, req_ready, fifo_wr_data, grant_id} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs got busy=%b en=%b rdy=%b data=%h gid=%0d exp all 0",
               busy, fifo_wr_en, req_ready, fifo_wr_data, grant_id);
    end
`ifdef FIFO_WR_ARB_STATS_EN
    n_cmp++;
    if ({beat_cnt, stall_cnt} !== '0) begin
      n_err++;
      $display("FAIL reset_counters got beat=%h stall=%0d exp 0", beat_cnt, stall_cnt);
    end
`endif
    @(posedge clk); #1;
    wr_rst = 1'b0;
  endtask

  task automatic test_single_pkt();
    logic eb;
    do_reset();
    @(negedge clk);
    load(0, 8'h11, 1'b0); load(0, 8'h22, 1'b0); load(0, 8'h33, 1'b1);
    exp_push(0, 8'h11); exp_push(0, 8'h22); exp_push(0, 8'h33);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      eb = (c >= 2 && c <= 4);
      n_cmp++;
      if ({busy, fifo_wr_en} !== {eb, eb}) begin
        n_err++;
        $display("FAIL single_c%0d got busy=%b en=%b exp %b%b", c, busy, fifo_wr_en, eb, eb);
      end
      if (c == 1) begin
        n_cmp++;
        if (req_ready !== 4'b0000) begin
          n_err++;
          $display("FAIL single_idle_ready got %b exp 0000", req_ready);
        end
      end
    end
  endtask

  task automatic test_round_robin();
    int order [5];
    logic ee;
    order = '{0, 1, 2, 3, 0};
    do_reset();
    @(negedge clk);
    for (int i = 0; i < NR; i++) load(i, 8'hA0 + 8'(i), 1'b1);
    load(0, 8'hB0, 1'b1);
    for (int i = 0; i < NR; i++) exp_push(i, 8'hA0 + 8'(i));
    exp_push(0, 8'hB0);
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      ee = (c % 2 == 0) && (c <= 10);
      n_cmp++;
      if (fifo_wr_en !== ee) begin
        n_err++;
        $display("FAIL rr_c%0d wr_en got %b exp %b", c, fifo_wr_en, ee);
      end
      if (ee) begin
        n_cmp++;
        if (grant_id !== 2'(order[c/2-1])) begin
          n_err++;
          $display("FAIL rr_c%0d grant got %0d exp %0d", c, grant_id, order[c/2-1]);
        end
      end
    end
  endtask

  task automatic test_full_stall();
    do_reset();
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      load(2, 8'h41 + 8'(k), k == 3);
      exp_push(2, 8'h41 + 8'(k));
    end
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    fifo_full = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({busy, fifo_wr_en, req_ready, grant_id} !== {1'b1, 1'b0, 4'b0000, 2'd2}) begin
        n_err++;
        $display("FAIL stall_c%0d got busy=%b en=%b rdy=%b gid=%0d exp 1 0 0000 2",
                 c, busy, fifo_wr_en, req_ready, grant_id);
      end
    end
    @(posedge clk); #1;
    fifo_full = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (fifo_wr_en !== 1'b1) begin
      n_err++;
      $display("FAIL stall_resume wr_en got %b exp 1", fifo_wr_en);
    end
`ifdef FIFO_WR_ARB_STATS_EN
    n_cmp++;
    if (stall_cnt !== 4'd5) begin
      n_err++;
      $display("FAIL stall_cnt got %0d exp 5", stall_cnt);
    end
`endif
    repeat (2) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL stall_done busy got %b exp 0", busy);
    end
  endtask

  task automatic test_lock_hold();
    logic       ee;
    logic [1:0] eg;
    do_reset();
    @(negedge clk);
    load(1, 8'h51, 1'b0); load(1, 8'h52, 1'b0); load(1, 8'h53, 1'b1);
    exp_push(1, 8'h51); exp_push(1, 8'h52); exp_push(1, 8'h53); exp_push(3, 8'h5F);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      ee = (c >= 2 && c <= 4) || (c == 6);
      eg = (c == 6) ? 2'd3 : 2'd1;
      n_cmp++;
      if (fifo_wr_en !== ee || (ee && grant_id !== eg)) begin
        n_err++;
        $display("FAIL lock_c%0d got en=%b gid=%0d exp en=%b gid=%0d", c, fifo_wr_en, grant_id, ee, eg);
      end
      if (c == 3 || c == 4) begin
        n_cmp++;
        if (req_ready !== 4'b0010) begin
          n_err++;
          $display("FAIL lock_ready_c%0d got %b exp 0010", c, req_ready);
        end
      end
      if (c == 2) load(3, 8'h5F, 1'b1);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(negedge clk);
    load(0, 8'h61, 1'b1); exp_push(0, 8'h61);
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) load(1, 8'h71 + 8'(k), k == 3);
    exp_push(1, 8'h71); exp_push(1, 8'h72);
    repeat (3) @(negedge clk);
    hold[1] = 1'b1;
    @(posedge clk); #1;
    wr_rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({busy, fifo_wr_en} !== 2'b10) begin
      n_err++;
      $display("FAIL rstmid_pre got busy=%b en=%b exp 1 0", busy, fifo_wr_en);
    end
    @(posedge clk); #1;
    wr_rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({busy, fifo_wr_en, req_ready, grant_id} !== '0) begin
      n_err++;
      $display("FAIL rstmid_post got busy=%b en=%b rdy=%b gid=%0d exp all 0",
               busy, fifo_wr_en, req_ready, grant_id);
    end
`ifdef FIFO_WR_ARB_STATS_EN
    n_cmp++;
    if ({beat_cnt, stall_cnt} !== '0) begin
      n_err++;
      $display("FAIL rstmid_counters got beat=%h stall=%0d exp 0", beat_cnt, stall_cnt);
    end
`endif
    rp[1] = wp[1];
    hold  = '0;
    load(1, 8'h82, 1'b1); load(0, 8'h81, 1'b1);
    exp_push(0, 8'h81); exp_push(1, 8'h82);
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({fifo_wr_en, grant_id} !== {1'b1, 2'd0}) begin
      n_err++;
      $display("FAIL rstmid_first got en=%b gid=%0d exp 1 0", fifo_wr_en, grant_id);
    end
    repeat (3) @(negedge clk);
  endtask

`ifdef FIFO_WR_ARB_STATS_EN
  task automatic test_stats_clr();
    do_reset();
    @(negedge clk);
    load(0, 8'h91, 1'b0); load(0, 8'h92, 1'b1);
    exp_push(0, 8'h91); exp_push(0, 8'h92);
    @(negedge clk);
    @(posedge clk); #1;
    stats_clr = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    stats_clr = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (beat_cnt[0 +: CW] !== 4'd0) begin
      n_err++;
      $display("FAIL clr_wins got %0d exp 0", beat_cnt[0 +: CW]);
    end
    @(negedge clk);
    n_cmp++;
    if (beat_cnt[0 +: CW] !== 4'd1) begin
      n_err++;
      $display("FAIL clr_after got %0d exp 1", beat_cnt[0 +: CW]);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    @(negedge clk);
    for (int k = 0; k < 16; k++) begin
      load(2, 8'hC0 + 8'(k), k == 15);
      exp_push(2, 8'hC0 + 8'(k));
    end
    repeat (19) @(negedge clk);
    n_cmp++;
    if ({busy, beat_cnt[2*CW +: CW], beat_cnt[0 +: CW]} !== {1'b0, 4'd15, 4'd0}) begin
      n_err++;
      $display("FAIL saturate got busy=%b cnt2=%0d cnt0=%0d exp 0 15 0",
               busy, beat_cnt[2*CW +: CW], beat_cnt[0 +: CW]);
    end
  endtask
`endif

  initial begin
    #50000;
    $display("FAIL watchdog timeout compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    wr_rst    = 1'b1;
    fifo_full = 1'b0;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    hold      = '0;
    acc_s     = '0;
    for (int i = 0; i < NR; i++) begin wp[i] = 0; rp[i] = 0; end
`ifdef FIFO_WR_ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    test_reset();
    test_single_pkt();
    test_round_robin();
    test_full_stall();
    test_lock_hold();
    test_reset_mid();
`ifdef FIFO_WR_ARB_STATS_EN
    test_stats_clr();
    test_saturate();
`endif
    repeat (2) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL sb_leftover got %0d pending writes exp 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
